hdr_restart_detector: RTL and testbench
=======================================

# hdr_restart_detector

Detects the I3C HDR Restart pattern on the SCL/SDA bus lines and signals completion to the CCC/HDR controller. While armed by the controller, it watches for two SDA falling edges and two SDA rising edges with SCL held low, followed by an SCL rising edge with SDA high. On that edge it emits a single-cycle done pulse. It sits in the exit/restart detection path, in parallel with the HDR Exit detector, and is clocked by the system clock.

## Interface
- No parameters.
- i_sys_clk  input  1  system clock; all logic on its rising edge.
- i_sys_rst  input  1  reset, synchronous, active-high.
- i_cccnt_enable  input  1  arm; detection runs only while high.
- i_scl  input  1  bus SCL level, asynchronous to i_sys_clk.
- i_sda  input  1  bus SDA level, asynchronous to i_sys_clk.
- o_cccnt_done  output  1  registered one-cycle pulse: Restart pattern completed.

## Operation
- Sampling:
  - scl_q/sda_q register the (optionally synchronized) inputs each clock.
  - scl_p/sda_p hold the previous samples.
  - Edge definitions: fall = p & ~q; rise = ~p & q.
- FSM states: IDLE, F1, R1, F2, R2, WAIT_SCL, ABORT.
- IDLE → F1 when enable=1, scl_q=0, sda_q=1.
- F1 → R1 on SDA fall with scl_q=0.
- R1 → F2 on SDA rise with scl_q=0.
- F2 → R2 on SDA fall with scl_q=0.
- R2 → WAIT_SCL on SDA rise with scl_q=0.
- WAIT_SCL:
  - SCL rise with sda_q=1 → set o_cccnt_done=1 for one cycle, go to IDLE.
  - SDA fall → ABORT (this is an Exit pattern, not a Restart).
- Abort rules:
  - In F1..R2, scl_q=1 → ABORT.
  - ABORT → IDLE once scl_q=0 and sda_q=1 are both seen. No done pulse is ever generated from ABORT.
- Enable low in any state → IDLE next clock, o_cccnt_done=0. There is no memory of a partial pattern.
- Simultaneous SCL rise and SDA edge in the same sample:
  - F1..R2: treated as abort.
  - WAIT_SCL: valid only if sda_q=1 after the edge.
- After done, the FSM re-arms from IDLE if enable stays high; back-to-back Restarts are each detected.

## Timing
- Reset (sync, active-high):
  - state = IDLE
  - scl_q/scl_p/sda_q/sda_p = 1 (bus idle)
  - synchronizer flops = 1
  - o_cccnt_done = 0
- Reset has priority over enable and all edges; reset mid-pattern discards progress.
- Latency without synchronizer: SCL rise captured into scl_q at clock edge k; o_cccnt_done is high during the cycle after edge k+1. That is 2 edges from the input change.
- o_cccnt_done is exactly 1 cycle wide and is registered (no combinational path from inputs).
- Bus levels must be stable for at least 1 clock period between transitions. Shorter glitches may be missed; this is not required to be filtered.

## Configuration
- RESTART_DET_SYNC_EN:
  - Defined: i_scl and i_sda each pass through a 2-flop synchronizer (reset value 1) before scl_q/sda_q. All latencies grow by 2 clocks.
  - Undefined: inputs feed scl_q/sda_q directly; latency is as stated above.

## Test plan
- Nominal Restart (clk period 10):
  - Reset, then enable=1, SCL=0, SDA=1.
  - Toggle SDA every 20 ns four times (0,1,0,1), then raise SCL.
  - Required: o_cccnt_done=1 for exactly 1 cycle, 2 clocks after the SCL rise (4 with RESTART_DET_SYNC_EN). It is 0 at all other times.
- Exit pattern: four SDA falls with SCL low, then SCL rise → o_cccnt_done stays 0; FSM reaches ABORT, then IDLE.
- Premature SCL: SCL rises after only one SDA fall/rise → no pulse. A full Restart that follows is detected.
- Enable drop: enable=0 after the second SDA fall, then the pattern completes → no pulse. Re-enable plus a full pattern → pulse.
- Reset: assert i_sys_rst during WAIT_SCL, then SCL rises → no pulse; output 0 during and after reset.
- Back-to-back: two consecutive valid Restart patterns with enable held high → two separate 1-cycle pulses.

Source files
------------

// File: rtl/hdr_restart_detector.sv
`default_nettype none
// ============================================================================
// Module   : hdr_restart_detector
// Purpose  : Detects the I3C HDR Restart pattern on SCL/SDA. While armed, it
//            looks for two SDA falling edges and two SDA rising edges with
//            SCL low, followed by an SCL rising edge with SDA high, and then
//            emits a registered single-cycle done pulse.
// Ports    : i_sys_clk      - system clock, rising edge
//            i_sys_rst      - synchronous active-high reset
//            i_cccnt_enable - arm; detection runs only while high
//            i_scl, i_sda   - bus levels, asynchronous to i_sys_clk
//            o_cccnt_done   - one-cycle pulse, Restart pattern completed
// Config   : RESTART_DET_SYNC_EN - when defined, i_scl/i_sda each pass through
//            a 2-flop synchronizer (reset value 1); latency grows by 2 clocks.
// Revision : 1.0 - initial release
// ============================================================================
module hdr_restart_detector (
    input  logic i_sys_clk,
    input  logic i_sys_rst,
    input  logic i_cccnt_enable,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_cccnt_done
);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_F1       = 3'd1;
    localparam logic [2:0] c_R1       = 3'd2;
    localparam logic [2:0] c_F2       = 3'd3;
    localparam logic [2:0] c_R2       = 3'd4;
    localparam logic [2:0] c_WAIT_SCL = 3'd5;
    localparam logic [2:0] c_ABORT    = 3'd6;

    logic       w_scl_in;
    logic       w_sda_in;
    logic       r_scl_q;
    logic       r_scl_p;
    logic       r_sda_q;
    logic       r_sda_p;
    logic       w_sda_fall;
    logic       w_sda_rise;
    logic       w_scl_rise;
    logic [2:0] r_state;
    logic [2:0] w_state_next;
    logic       w_done_next;
    logic       r_done;

`ifdef RESTART_DET_SYNC_EN
    // Two-flop synchronizers; reset to 1 so the bus looks idle after reset.
    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_sync <= {r_sda_sync[0], i_sda};
        end
    end

    assign w_scl_in = r_scl_sync[1];
    assign w_sda_in = r_sda_sync[1];
`else
    assign w_scl_in = i_scl;
    assign w_sda_in = i_sda;
`endif

    // Current/previous samples; edges are derived from these registers only.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_scl_q <= 1'b1;
            r_scl_p <= 1'b1;
            r_sda_q <= 1'b1;
            r_sda_p <= 1'b1;
        end else begin
            r_scl_q <= w_scl_in;
            r_scl_p <= r_scl_q;
            r_sda_q <= w_sda_in;
            r_sda_p <= r_sda_q;
        end
    end

    assign w_sda_fall = r_sda_p & ~r_sda_q;
    assign w_sda_rise = ~r_sda_p & r_sda_q;
    assign w_scl_rise = ~r_scl_p & r_scl_q;

    // State register and registered done pulse.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_state <= c_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
        end
    end

    // Next-state logic. In the toggle-tracking states, SCL high is checked
    // first so an SCL rise coinciding with an SDA edge counts as an abort.
    always_comb begin
        w_state_next = r_state;
        if (!i_cccnt_enable) begin
            w_state_next = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (!r_scl_q && r_sda_q) w_state_next = c_F1;
                end
                c_F1: begin
                    if (r_scl_q)         w_state_next = c_ABORT;
                    else if (w_sda_fall) w_state_next = c_R1;
                end
                c_R1: begin
                    if (r_scl_q)         w_state_next = c_ABORT;
                    else if (w_sda_rise) w_state_next = c_F2;
                end
                c_F2: begin
                    if (r_scl_q)         w_state_next = c_ABORT;
                    else if (w_sda_fall) w_state_next = c_R2;
                end
                c_R2: begin
                    if (r_scl_q)         w_state_next = c_ABORT;
                    else if (w_sda_rise) w_state_next = c_WAIT_SCL;
                end
                c_WAIT_SCL: begin
                    // A further SDA fall makes this an Exit, not a Restart.
                    if (w_scl_rise && r_sda_q) w_state_next = c_IDLE;
                    else if (w_sda_fall)       w_state_next = c_ABORT;
                end
                c_ABORT: begin
                    if (!r_scl_q && r_sda_q) w_state_next = c_IDLE;
                end
                default: begin
                    w_state_next = c_IDLE;
                end
            endcase
        end
    end

    // Output logic: the pulse is requested on the completing SCL rise and
    // appears from the register one clock later.
    always_comb begin
        w_done_next = 1'b0;
        if (i_cccnt_enable && (r_state == c_WAIT_SCL) && w_scl_rise && r_sda_q) begin
            w_done_next = 1'b1;
        end
    end

    assign o_cccnt_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_hdr_restart_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdr_restart_detector
// Purpose  : Self-checking bench for hdr_restart_detector. A pattern-level
//            model (count of alternating SDA edges seen with SCL low) predicts
//            o_cccnt_done every cycle; directed scenarios pin pulse counts and
//            latency with literal values; randomized segments follow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdr_restart_detector;

`ifdef RESTART_DET_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int HIST_DEPTH = SYNC_LAT + 2;

    logic i_sys_clk_tb = 1'b0;
    logic sys_rst      = 1'b1;
    logic cccnt_enable = 1'b0;
    logic scl          = 1'b1;
    logic sda          = 1'b1;
    logic cccnt_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses = 0;
    int first_pulse_cyc = -1;
    int last_rise_cyc = 0;

    always #5 i_sys_clk_tb = ~i_sys_clk_tb;

    hdr_restart_detector dut (
        .i_sys_clk      (i_sys_clk_tb),
        .i_sys_rst      (sys_rst),
        .i_cccnt_enable (cccnt_enable),
        .i_scl          (scl),
        .i_sda          (sda),
        .o_cccnt_done   (cccnt_done)
    );

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_TRACK, M_WAIT, M_ABORT} mode_t;
    mode_t      mode = M_IDLE;
    int         n_edges = 0;
    logic       exp_done = 1'b0;
    logic [1:0] hist[$];   // {scl,sda}; [0] = previous sample, [1] = current sample

    always @(posedge i_sys_clk_tb) begin : model_and_compare
        logic [1:0] prv;
        logic [1:0] cur;
        logic       sfall;
        logic       srise;
        logic       crise;
        cyc++;
        if (sys_rst) begin
            hist.delete();
            for (int i = 0; i < HIST_DEPTH; i++) hist.push_back(2'b11);
            mode     = M_IDLE;
            n_edges  = 0;
            exp_done = 1'b0;
        end else begin
            prv      = hist[0];
            cur      = hist[1];
            sfall    = prv[0] & ~cur[0];
            srise    = ~prv[0] & cur[0];
            crise    = ~prv[1] & cur[1];
            exp_done = 1'b0;
            if (!cccnt_enable) begin
                mode = M_IDLE;
            end else begin
                case (mode)
                    M_IDLE: if (!cur[1] && cur[0]) begin mode = M_TRACK; n_edges = 0; end
                    M_TRACK: begin
                        if (cur[1]) mode = M_ABORT;
                        else if ((n_edges % 2 == 0) ? sfall : srise) begin
                            n_edges++;
                            if (n_edges == 4) mode = M_WAIT;
                        end
                    end
                    M_WAIT: begin
                        if (crise && cur[0]) begin exp_done = 1'b1; mode = M_IDLE; end
                        else if (sfall) mode = M_ABORT;
                    end
                    M_ABORT: if (!cur[1] && cur[0]) mode = M_IDLE;
                    default: mode = M_IDLE;
                endcase
            end
            hist.push_back({scl, sda});
            void'(hist.pop_front());
        end
        #1;
        if (cccnt_done === 1'b1) begin
            pulses++;
            if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
        end
        checks++;
        if (cccnt_done !== exp_done) begin
            errors++;
            $display("FAIL done_vs_model cyc=%0d actual=%b expected=%b", cyc, cccnt_done, exp_done);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic drive(input logic s, input logic d, input logic e, input int hold);
        @(negedge i_sys_clk_tb);
        if (s && !scl) last_rise_cyc = cyc + 1;
        scl          = s;
        sda          = d;
        cccnt_enable = e;
        repeat (hold - 1) @(negedge i_sys_clk_tb);
    endtask

    task automatic settle();
        repeat (6 + SYNC_LAT) @(negedge i_sys_clk_tb);
    endtask

    task automatic clear_window();
        pulses          = 0;
        first_pulse_cyc = -1;
    endtask

    task automatic restart_seq(input int hlo, input int hhi);
        logic [1:0] seq [6];
        seq = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b11};
        for (int i = 0; i < 6; i++) drive(seq[i][1], seq[i][0], 1'b1, $urandom_range(hhi, hlo));
    endtask

    task automatic exit_seq(input int hlo, input int hhi);
        logic [1:0] seq [10];
        seq = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b11};
        for (int i = 0; i < 10; i++) drive(seq[i][1], seq[i][0], 1'b1, $urandom_range(hhi, hlo));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge i_sys_clk_tb);
        check("reset_done_low", int'(cccnt_done), 0);
        sys_rst = 1'b0;

        // Nominal restart: one pulse, 1+SYNC_LAT cycles after the capturing edge.
        clear_window();
        restart_seq(2, 2);
        settle();
        check("nominal_pulses", pulses, 1);
        check("nominal_latency", first_pulse_cyc - last_rise_cyc, 1 + SYNC_LAT);

        // Exit pattern: no pulse; a following restart is still detected.
        clear_window();
        exit_seq(2, 2);
        settle();
        check("exit_pulses", pulses, 0);
        clear_window();
        restart_seq(2, 2);
        settle();
        check("after_exit_pulses", pulses, 1);

        // Premature SCL after one fall/rise pair.
        clear_window();
        drive(1'b0, 1'b1, 1'b1, 2);
        drive(1'b0, 1'b0, 1'b1, 2);
        drive(1'b0, 1'b1, 1'b1, 2);
        drive(1'b1, 1'b1, 1'b1, 2);
        settle();
        check("premature_pulses", pulses, 0);
        clear_window();
        restart_seq(2, 2);
        settle();
        check("after_premature_pulses", pulses, 1);

        // Enable dropped after the second SDA fall.
        clear_window();
        drive(1'b0, 1'b1, 1'b1, 2);
        drive(1'b0, 1'b0, 1'b1, 2);
        drive(1'b0, 1'b1, 1'b1, 2);
        drive(1'b0, 1'b0, 1'b1, 2);
        drive(1'b0, 1'b1, 1'b0, 2);
        drive(1'b1, 1'b1, 1'b0, 2);
        settle();
        check("enable_drop_pulses", pulses, 0);
        clear_window();
        restart_seq(2, 2);
        settle();
        check("reenable_pulses", pulses, 1);

        // Reset while waiting for the SCL rise.
        clear_window();
        drive(1'b0, 1'b1, 1'b1, 2);
        drive(1'b0, 1'b0, 1'b1, 2);
        drive(1'b0, 1'b1, 1'b1, 2);
        drive(1'b0, 1'b0, 1'b1, 2);
        drive(1'b0, 1'b1, 1'b1, 3 + SYNC_LAT);
        @(negedge i_sys_clk_tb);
        sys_rst = 1'b1;
        repeat (2) @(negedge i_sys_clk_tb);
        check("during_reset_done", int'(cccnt_done), 0);
        sys_rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 2);
        settle();
        check("reset_mid_pattern_pulses", pulses, 0);
        check("after_reset_done", int'(cccnt_done), 0);

        // Back-to-back restarts.
        clear_window();
        restart_seq(2, 2);
        restart_seq(2, 2);
        settle();
        check("back_to_back_pulses", pulses, 2);

        // Randomized segments; the per-cycle model comparison does the checking.
        for (int seg = 0; seg < 80; seg++) begin
            case ($urandom_range(4, 0))
                0: restart_seq(1, 3);
                1: exit_seq(1, 3);
                2: for (int i = 0; i < 6; i++)
                       drive(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b1,
                             $urandom_range(3, 1));
                3: begin
                    int         drop;
                    logic [1:0] seq [6];
                    seq  = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b11};
                    drop = $urandom_range(5, 0);
                    for (int i = 0; i < 6; i++)
                        drive(seq[i][1], seq[i][0], (i != drop), $urandom_range(3, 1));
                end
                default: begin
                    drive(1'b0, 1'b1, 1'b1, $urandom_range(3, 1));
                    drive(1'b0, 1'b0, 1'b1, $urandom_range(3, 1));
                    drive(1'b0, 1'b1, 1'b1, $urandom_range(3, 1));
                    @(negedge i_sys_clk_tb);
                    sys_rst = 1'b1;
                    repeat ($urandom_range(2, 1)) @(negedge i_sys_clk_tb);
                    sys_rst = 1'b0;
                    restart_seq(1, 3);
                end
            endcase
        end
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
